// File: rtl/adder_32bit_pkg.sv
// -----------------------------------------------------------------------------
// adder_32bit_pkg
// Shared constants and types for the ALU add/subtract datapath.
//   ADDER_WIDTH : operand/result width of the adder (32)
//   CLA_GROUP   : bit width of one first-level carry-lookahead group (4)
//   word_t      : ADDER_WIDTH-bit operand/result word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package adder_32bit_pkg;

  localparam int ADDER_WIDTH = 32;
  localparam int CLA_GROUP   = 4;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : adder_32bit_pkg

// File: rtl/adder_32bit_cla_4bit.sv
// -----------------------------------------------------------------------------
// cla_4bit
// First-level 4-bit carry-lookahead group. Computes the group sum from the
// carry supplied by the second-level unit, and exports the group propagate
// and generate terms that the second level uses to derive that carry.
//   a, b : 4-bit operand slices
//   cin  : carry into bit 0 of this group
//   s    : 4-bit sum slice
//   p    : group propagate (all four bits propagate)
//   g    : group generate (group produces a carry regardless of cin)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cla_4bit
  import adder_32bit_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 p,
  output logic                 g
);

  logic [CLA_GROUP-1:0] bit_p;
  logic [CLA_GROUP-1:0] bit_g;
  logic [CLA_GROUP-1:0] c;    // c[i] = carry into bit i of the group

  assign bit_p = a ^ b;
  assign bit_g = a & b;

  // Every internal carry is written as a flat sum of products so no carry
  // depends on the previous one; this is the lookahead, not a ripple.
  assign c[0] = cin;
  assign c[1] = bit_g[0]
              | (bit_p[0] & cin);
  assign c[2] = bit_g[1]
              | (bit_p[1] & bit_g[0])
              | (bit_p[1] & bit_p[0] & cin);
  assign c[3] = bit_g[2]
              | (bit_p[2] & bit_g[1])
              | (bit_p[2] & bit_p[1] & bit_g[0])
              | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign s = bit_p ^ c;

  assign p = &bit_p;
  assign g = bit_g[3]
           | (bit_p[3] & bit_g[2])
           | (bit_p[3] & bit_p[2] & bit_g[1])
           | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);

endmodule : cla_4bit

// File: rtl/adder_32bit.sv
// -----------------------------------------------------------------------------
// adder_32bit
// Registered two's-complement adder used as the ALU add/subtract datapath.
// Subtraction is done upstream by presenting ~y with c_in = 1.
// Two-level carry lookahead: WIDTH/4 cla_4bit groups plus a second-level
// unit that derives each group's carry-in from the group P/G terms.
// One pipeline stage: inputs before rising edge N give outputs after edge N.
//   clk   : system clock, rising-edge
//   rst_n : asynchronous active-low reset, clears all outputs
//   c_in  : carry into bit 0
//   x, y  : operands
//   sum   : registered (x + y + c_in) mod 2^WIDTH
//   c_out : registered carry out of the MSB (unsigned overflow)
//   v     : registered signed overflow
// WIDTH must be a multiple of CLA_GROUP.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module adder_32bit
  import adder_32bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v
);

  localparam int NUM_GRP = WIDTH / CLA_GROUP;

  logic [NUM_GRP-1:0] grp_p;
  logic [NUM_GRP-1:0] grp_g;
  logic [NUM_GRP:0]   grp_c;    // grp_c[k] = carry into group k; [NUM_GRP] = c_out

  logic [WIDTH-1:0]   sum_d;
  logic               c_out_d;
  logic               v_d;

  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;
  logic               v_q;

  // ---------------------------------------------------------------------------
  // First level: 4-bit lookahead groups
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_cla
    cla_4bit u_cla (
      .a   (x[gi*CLA_GROUP +: CLA_GROUP]),
      .b   (y[gi*CLA_GROUP +: CLA_GROUP]),
      .cin (grp_c[gi]),
      .s   (sum_d[gi*CLA_GROUP +: CLA_GROUP]),
      .p   (grp_p[gi]),
      .g   (grp_g[gi])
    );
  end : g_cla

  // ---------------------------------------------------------------------------
  // Second level: group carries as flat products of group P/G and c_in.
  // For carry into group k+1 the loop walks groups k down to 0, OR-ing in
  // each generate gated by the propagates above it, and finally c_in gated
  // by all propagates. The loop unrolls into sum-of-products, not a ripple.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    grp_c    = '0;
    grp_c[0] = c_in;
    for (int k = 0; k < NUM_GRP; k++) begin
      logic acc;
      logic run;
      acc = 1'b0;
      run = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (run & grp_g[j]);
        run = run & grp_p[j];
      end
      grp_c[k+1] = acc | (run & c_in);
    end
  end

  assign c_out_d = grp_c[NUM_GRP];

  // Signed overflow: operands agree in sign and the result does not. This is
  // identical to carry-into-MSB XOR carry-out-of-MSB, and it naturally
  // covers the c_in contribution since sum_d already includes it.
  assign v_d = (x[WIDTH-1] ~^ y[WIDTH-1]) & (sum_d[WIDTH-1] ^ x[WIDTH-1]);

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all three outputs share one async reset so nothing leaves
      // reset as X and an in-flight result is discarded immediately.
      sum_q   <= '0;
      c_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      v_q     <= v_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign v     = v_q;

endmodule : adder_32bit

// File: tb/tb_adder_32bit.sv
// -----------------------------------------------------------------------------
// tb_adder_32bit
// Self-checking bench for adder_32bit: reset behaviour, directed vectors with
// hand-computed results, a bit-toggle sweep on the sign/LSB bits and a random
// regression against an arithmetic reference ({c_out,sum} = x + y + c_in).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_32bit;
  import adder_32bit_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  c_in;
  word_t x;
  word_t y;
  word_t sum;
  logic  c_out;
  logic  v;

  int n_total;
  int n_bad;

  adder_32bit #(.WIDTH(ADDER_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c_in  (c_in),
    .x     (x),
    .y     (y),
    .sum   (sum),
    .c_out (c_out),
    .v     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must always end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one vector after the falling edge, let one rising edge register
  // it, then sample 1 time unit later.
  task automatic apply(input word_t a, input word_t b, input logic ci);
    @(negedge clk);
    x    = a;
    y    = b;
    c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input word_t es,
                            input logic ec, input logic ev);
    check({tag, ".sum"},   64'(sum),   64'(es));
    check({tag, ".c_out"}, 64'(c_out), 64'(ec));
    check({tag, ".v"},     64'(v),     64'(ev));
  endtask

  // Reference: plain 33-bit arithmetic, sign rule for v.
  function automatic logic [33:0] ref_add(input word_t a, input word_t b,
                                          input logic ci);
    logic [32:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov   = (a[31] == b[31]) && (full[31] != a[31]);
    return {full[32], ov, full[31:0]};
  endfunction

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    x       = 32'h1234_5678;
    y       = 32'h0000_0001;
    c_in    = 1'b1;

    // Reset held across several clock edges with nonzero inputs.
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_hold", 32'h0, 1'b0, 1'b0);

    // Release between edges; first result on the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_0005, 32'h0000_0003, 1'b0);
    expect_out("add_5_3", 32'h0000_0008, 1'b0, 1'b0);
    apply(32'h0000_0005, 32'h0000_0003, 1'b1);
    expect_out("add_5_3_cin", 32'h0000_0009, 1'b0, 1'b0);

    // Carry wrap.
    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("wrap_y1", 32'h0, 1'b1, 1'b0);
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    expect_out("wrap_cin", 32'h0, 1'b1, 1'b0);

    // Signed overflow cases.
    apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
    apply(32'h8000_0000, 32'h8000_0000, 1'b0);
    expect_out("ovf_neg_neg", 32'h0, 1'b1, 1'b1);
    apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_out("ovf_min_m1", 32'h7FFF_FFFF, 1'b1, 1'b1);
    apply(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    expect_out("ovf_cin", 32'h8000_0000, 1'b0, 1'b1);

    // Full carry propagation across groups.
    apply(32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
    expect_out("prop_28", 32'h1000_0000, 1'b0, 1'b0);
    apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    expect_out("prop_all", 32'h0, 1'b1, 1'b0);
    apply(32'h1234_5678, 32'h1111_1111, 1'b0);
    expect_out("plain", 32'h2345_6789, 1'b0, 1'b0);
    // Subtraction as the ALU does it: 10 - 3 = 10 + ~3 + 1.
    apply(32'h0000_000A, 32'hFFFF_FFFC, 1'b1);
    expect_out("sub_10_3", 32'h0000_0007, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a nonzero result registered.
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    expect_out("pre_async", 32'hFFFF_FFFF, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Toggle sweep: x[0], y[0], x[31], y[31], x[30], y[30] flipped with
    // periods of 1..6 cycles over a fixed background.
    begin
      word_t tx;
      word_t ty;
      logic [33:0] exp;
      tx = 32'h3C5A_0F0E;
      ty = 32'h0F0F_F0F0;
      for (int n = 1; n <= 240; n++) begin
        if (n % 1 == 0) tx[0]  = ~tx[0];
        if (n % 2 == 0) ty[0]  = ~ty[0];
        if (n % 3 == 0) tx[31] = ~tx[31];
        if (n % 4 == 0) ty[31] = ~ty[31];
        if (n % 5 == 0) tx[30] = ~tx[30];
        if (n % 6 == 0) ty[30] = ~ty[30];
        exp = ref_add(tx, ty, n[0]);
        apply(tx, ty, n[0]);
        check("toggle", {30'd0, c_out, v, sum}, {30'd0, exp});
      end
    end

    // Random regression.
    for (int n = 0; n < 10000; n++) begin
      word_t ra;
      word_t rb;
      logic  rc;
      logic [33:0] exp;
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(1, 0));
      exp = ref_add(ra, rb, rc);
      apply(ra, rb, rc);
      check("random", {30'd0, c_out, v, sum}, {30'd0, exp});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_adder_32bit
